alu_issue_stage: RTL and testbench
==================================

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, giving the datapath width; only 32 is supported.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have the following input ports:
- in_valid, 1 bit: an instruction is offered.
- instr, 32 bits: RV32I instruction word.
- pc, 32 bits: address of instr.
- rs1_data, 32 bits: source register 1 value.
- rs2_data, 32 bits: source register 2 value.
REQ-005 SHALL have port in_ready, output, 1 bit: the stage accepts on the same cycle that in_valid is high.
REQ-006 SHALL have ports out_valid (output, 1 bit) and out_ready (input, 1 bit): the downstream EX handshake.
REQ-007 SHALL have ports flush (input, 1 bit), which kills the held entry, and stall (input, 1 bit), which blocks acceptance.
REQ-008 SHALL have outputs alu_a, alu_b (32 bits each) and alu_control (4 bits): the ALU operands and operation code.
REQ-009 SHALL have outputs store_data (32 bits) and rd (5 bits).
REQ-010 SHALL have 1-bit outputs reg_write, mem_read, mem_write, branch, branch_inv, jump and illegal.

Function
REQ-011 SHALL be a one-entry registered stage: the fields of an accepted instruction appear on the outputs on the next rising edge with out_valid=1 (latency 1).
REQ-012 SHALL drive in_ready = !stall && !flush && (!out_valid || out_ready); acceptance occurs when in_valid && in_ready.
REQ-013 SHALL hold every output stable while out_valid && !out_ready.
REQ-014 SHALL clear out_valid on the edge after out_valid && out_ready when nothing new is accepted.
- On simultaneous drain and accept, it SHALL load the new entry (full throughput, one per cycle).
REQ-015 SHALL give flush priority over every event: on the next edge out_valid=0, and any in_valid presented that cycle is dropped.
REQ-016 SHALL use these alu_control codes: ADD 0000, SUB 0001, XOR 0010, OR 0011, AND 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, EQ 1001, GE 1010, SLTU 1011.
REQ-017 SHALL decode OP (0110011) as follows, with alu_a=rs1_data and alu_b=rs2_data:
- funct3 000: ADD, or SUB when funct7[5]=1.
- 001: SLL. 010: SLT. 011: SLTU. 100: XOR.
- 101: SRL, or SRA when funct7[5]=1.
- 110: OR. 111: AND.
REQ-018 SHALL decode OP-IMM (0010011) with the same funct3 mapping as OP, with these differences:
- funct3 000 is always ADD.
- alu_b is the sign-extended I-immediate.
- For shifts, alu_b is instr[24:20] zero-extended, and instr[30] selects SRA.
REQ-019 SHALL decode LOAD/STORE as ADD with alu_a=rs1_data:
- alu_b is the sign-extended I-immediate (LOAD) or S-immediate (STORE).
- mem_read or mem_write is asserted respectively.
- store_data=rs2_data.
REQ-020 SHALL decode BRANCH (1100011) with branch=1 and reg_write=0, setting alu_control and branch_inv as follows:
- BEQ: SUB, branch_inv=0. BNE: SUB, branch_inv=1.
- BLT: SLT, branch_inv=0. BGE: SLT, branch_inv=1.
- BLTU: SLTU, branch_inv=0. BGEU: SLTU, branch_inv=1.
- Both branch_inv=0 and branch_inv=1 are legal values.
REQ-021 SHALL decode LUI as ADD with alu_a=0 and alu_b={instr[31:12],12'b0}, and AUIPC the same with alu_a=pc.
REQ-022 SHALL decode JAL/JALR as ADD with alu_a=pc, alu_b=4, jump=1 and reg_write=1.
REQ-023 SHALL treat any other opcode, or a reserved funct3 under LOAD/STORE/BRANCH, as illegal: illegal=1, alu_control=ADD, and reg_write, mem_read, mem_write, branch and jump all 0.
REQ-024 SHALL force reg_write=0 when rd=0.

Reset
REQ-025 SHALL, while rst is high at a clock edge, clear out_valid and all output registers to 0 (alu_control=0000), regardless of in_valid, flush or stall.
REQ-026 SHALL hold in_ready at 0 during the reset cycle; a reset in the middle of a stall discards the held entry.

Structure
REQ-027 SHALL take the alu_control codes, RV32I opcode constants and funct3 constants from a shared package alu_pkg, which the ALU also uses.
REQ-028 SHALL put immediate extraction in one combinational sub-module, imm_gen (inputs instr; outputs imm_i, imm_s, imm_u, shamt).

Verification
REQ-029 SHALL cover add: instr 0x002081B3, rs1_data=5, rs2_data=7 -> next cycle out_valid=1, alu_control=0000, alu_a=5, alu_b=7, rd=3, reg_write=1.
REQ-030 SHALL cover sub: instr 0x402081B3 -> alu_control=0001.
- Then addi: instr 0xFFF00093 -> alu_control=0000, alu_b=0xFFFFFFFF, rd=1.
REQ-031 SHALL cover srai: instr 0x40335293 -> alu_control=0111, alu_b=3, rd=5.
REQ-032 SHALL cover backpressure: out_ready=0 for 3 cycles with in_valid=1 -> outputs unchanged and in_ready=0.
- Then out_ready=1 -> the next instruction appears one cycle later.
REQ-033 SHALL cover flush: flush=1 while an entry is held and in_valid=1 -> out_valid=0 next cycle and the input is dropped.
REQ-034 SHALL cover illegal: instr 0x0000007F -> illegal=1, reg_write=0, mem_write=0, alu_control=0000.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, RV32I opcode and funct3 constants,
// the issue-stage payload record and the funct3-to-operation helper.
// No ports (package).
package alu_pkg;

   // ALU operation codes driven on alu_control
   typedef enum logic [3:0] {
      ALU_ADD  = 4'b0000,
      ALU_SUB  = 4'b0001,
      ALU_XOR  = 4'b0010,
      ALU_OR   = 4'b0011,
      ALU_AND  = 4'b0100,
      ALU_SLL  = 4'b0101,
      ALU_SRL  = 4'b0110,
      ALU_SRA  = 4'b0111,
      ALU_SLT  = 4'b1000,
      ALU_EQ   = 4'b1001,
      ALU_GE   = 4'b1010,
      ALU_SLTU = 4'b1011
   } alu_op_e;

   // RV32I major opcodes
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   // funct3 for OP / OP-IMM
   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SLT     = 3'b010;
   localparam logic [2:0] F3_SLTU    = 3'b011;
   localparam logic [2:0] F3_XOR     = 3'b100;
   localparam logic [2:0] F3_SRL_SRA = 3'b101;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;

   // funct3 for BRANCH
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   // funct3 for LOAD / STORE
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // Everything the stage hands to EX for one instruction
   typedef struct packed {
      logic [31:0] alu_a;
      logic [31:0] alu_b;
      logic [31:0] store_data;
      alu_op_e     alu_control;
      logic [4:0]  rd;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        branch;
      logic        branch_inv;
      logic        jump;
      logic        illegal;
   } issue_t;

   // OP/OP-IMM funct3 mapping; alt is the instr[30] modifier (SUB / SRA)
   function automatic alu_op_e f3_to_alu(input logic [2:0] f3, input logic alt);
      alu_op_e op;
      case (f3)
         F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
         F3_SLL:     op = ALU_SLL;
         F3_SLT:     op = ALU_SLT;
         F3_SLTU:    op = ALU_SLTU;
         F3_XOR:     op = ALU_XOR;
         F3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
         F3_OR:      op = ALU_OR;
         F3_AND:     op = ALU_AND;
         default:    op = ALU_ADD;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate extraction for RV32I (purely combinational).
// Ports: instr (in)  - instruction word
//        imm_i (out) - sign-extended I-immediate
//        imm_s (out) - sign-extended S-immediate
//        imm_u (out) - U-immediate, low 12 bits zero
//        shamt (out) - shift amount instr[24:20]
module imm_gen (
   input  logic [31:0] instr,
   output logic [31:0] imm_i,
   output logic [31:0] imm_s,
   output logic [31:0] imm_u,
   output logic [4:0]  shamt
);

   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_u = {instr[31:12], 12'h000};
   assign shamt = instr[24:20];

endmodule

// File: rtl/alu_issue_stage.sv
// One-entry registered issue stage: decodes an RV32I instruction into ALU
// operands/operation and control flags, holding them for the EX handshake.
// Ports: clk, rst (sync, active high)
//        in_valid/in_ready, instr, pc, rs1_data, rs2_data  - upstream side
//        out_valid/out_ready                               - EX handshake
//        flush (kills held entry), stall (blocks acceptance)
//        alu_a, alu_b, alu_control, store_data, rd, reg_write, mem_read,
//        mem_write, branch, branch_inv, jump, illegal      - registered payload
// XLEN must be 32; the payload record is fixed at 32 bits.
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   input  logic [31:0]     instr,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   output logic            in_ready,
   output logic            out_valid,
   input  logic            out_ready,
   input  logic            flush,
   input  logic            stall,
   output logic [XLEN-1:0] alu_a,
   output logic [XLEN-1:0] alu_b,
   output logic [3:0]      alu_control,
   output logic [XLEN-1:0] store_data,
   output logic [4:0]      rd,
   output logic            reg_write,
   output logic            mem_read,
   output logic            mem_write,
   output logic            branch,
   output logic            branch_inv,
   output logic            jump,
   output logic            illegal
);

   logic [31:0] w_imm_i;
   logic [31:0] w_imm_s;
   logic [31:0] w_imm_u;
   logic [4:0]  w_shamt;
   logic [6:0]  w_opcode;
   logic [2:0]  w_funct3;
   logic        w_accept;
   issue_t      w_dec;
   issue_t      r_out;
   logic        r_valid;

   imm_gen u_imm_gen (
      .instr (instr),
      .imm_i (w_imm_i),
      .imm_s (w_imm_s),
      .imm_u (w_imm_u),
      .shamt (w_shamt)
   );

   assign w_opcode = instr[6:0];
   assign w_funct3 = instr[14:12];

   // Reset also masks in_ready so nothing is taken on a reset edge.
   assign in_ready = !rst && !stall && !flush && (!r_valid || out_ready);
   assign w_accept = in_valid && in_ready;

   // Decode the offered instruction into the payload record
   always_comb begin
      w_dec            = '0;
      w_dec.rd         = instr[11:7];
      w_dec.alu_a      = rs1_data;
      w_dec.alu_b      = rs2_data;
      w_dec.store_data = rs2_data;
      case (w_opcode)
         OPC_OP: begin
            w_dec.alu_control = f3_to_alu(w_funct3, instr[30]);
            w_dec.reg_write   = 1'b1;
         end
         OPC_OP_IMM: begin
            w_dec.reg_write = 1'b1;
            // Shifts take shamt and honour instr[30]; ADDI never becomes SUB.
            if ((w_funct3 == F3_SLL) || (w_funct3 == F3_SRL_SRA)) begin
               w_dec.alu_b       = {27'd0, w_shamt};
               w_dec.alu_control = f3_to_alu(w_funct3, instr[30]);
            end else begin
               w_dec.alu_b       = w_imm_i;
               w_dec.alu_control = f3_to_alu(w_funct3, 1'b0);
            end
         end
         OPC_LOAD: begin
            case (w_funct3)
               F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: begin
                  w_dec.alu_b     = w_imm_i;
                  w_dec.mem_read  = 1'b1;
                  w_dec.reg_write = 1'b1;
               end
               default: w_dec.illegal = 1'b1;
            endcase
         end
         OPC_STORE: begin
            case (w_funct3)
               F3_LB, F3_LH, F3_LW: begin
                  w_dec.alu_b     = w_imm_s;
                  w_dec.mem_write = 1'b1;
               end
               default: w_dec.illegal = 1'b1;
            endcase
         end
         OPC_BRANCH: begin
            w_dec.branch = 1'b1;
            case (w_funct3)
               F3_BEQ:  w_dec.alu_control = ALU_SUB;
               F3_BNE:  begin w_dec.alu_control = ALU_SUB;  w_dec.branch_inv = 1'b1; end
               F3_BLT:  w_dec.alu_control = ALU_SLT;
               F3_BGE:  begin w_dec.alu_control = ALU_SLT;  w_dec.branch_inv = 1'b1; end
               F3_BLTU: w_dec.alu_control = ALU_SLTU;
               F3_BGEU: begin w_dec.alu_control = ALU_SLTU; w_dec.branch_inv = 1'b1; end
               default: w_dec.illegal = 1'b1;
            endcase
         end
         OPC_LUI: begin
            w_dec.alu_a     = 32'd0;
            w_dec.alu_b     = w_imm_u;
            w_dec.reg_write = 1'b1;
         end
         OPC_AUIPC: begin
            w_dec.alu_a     = pc;
            w_dec.alu_b     = w_imm_u;
            w_dec.reg_write = 1'b1;
         end
         OPC_JAL, OPC_JALR: begin
            // EX computes the link address pc+4; the target is resolved elsewhere.
            w_dec.alu_a     = pc;
            w_dec.alu_b     = 32'd4;
            w_dec.jump      = 1'b1;
            w_dec.reg_write = 1'b1;
         end
         default: w_dec.illegal = 1'b1;
      endcase

      // Illegal instructions leave EX inert: ADD and every side effect off.
      if (w_dec.illegal) begin
         w_dec         = '0;
         w_dec.illegal = 1'b1;
         w_dec.rd      = instr[11:7];
      end else begin
         w_dec.reg_write = w_dec.reg_write && (w_dec.rd != 5'd0);
      end
   end

   // Payload register: reset > flush > load > drain > hold
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out   <= '0;
         r_valid <= 1'b0;
      end else if (flush) begin
         r_valid <= 1'b0;
      end else if (w_accept) begin
         r_out   <= w_dec;
         r_valid <= 1'b1;
      end else if (out_ready) begin
         r_valid <= 1'b0;
      end else begin
         r_valid <= r_valid;
      end
   end

   assign out_valid   = r_valid;
   assign alu_a       = r_out.alu_a;
   assign alu_b       = r_out.alu_b;
   assign alu_control = r_out.alu_control;
   assign store_data  = r_out.store_data;
   assign rd          = r_out.rd;
   assign reg_write   = r_out.reg_write;
   assign mem_read    = r_out.mem_read;
   assign mem_write   = r_out.mem_write;
   assign branch      = r_out.branch;
   assign branch_inv  = r_out.branch_inv;
   assign jump        = r_out.jump;
   assign illegal     = r_out.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed vector table, hand-written
// handshake sequences, then randomized traffic against a reference model.
module tb_alu_issue_stage;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [31:0] instr;
   logic [31:0] pc;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic        in_ready;
   logic        out_valid;
   logic        out_ready;
   logic        flush;
   logic        stall;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [3:0]  alu_control;
   logic [31:0] store_data;
   logic [4:0]  rd;
   logic        reg_write;
   logic        mem_read;
   logic        mem_write;
   logic        branch;
   logic        branch_inv;
   logic        jump;
   logic        illegal;

   int n_checks = 0;
   int n_errors = 0;

   alu_issue_stage #(.XLEN(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .instr(instr), .pc(pc),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_ready(out_ready), .flush(flush), .stall(stall),
      .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
      .store_data(store_data), .rd(rd), .reg_write(reg_write),
      .mem_read(mem_read), .mem_write(mem_write), .branch(branch),
      .branch_inv(branch_inv), .jump(jump), .illegal(illegal)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Expected payload of one instruction
   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] sd;
      logic [3:0]  ctrl;
      logic [4:0]  rd;
      logic        rw, mr, mw, br, bi, jp, il;
   } exp_t;

   // Directed vector: stimulus plus hand-computed expectations
   typedef struct {
      logic [31:0] instr, pc, rs1, rs2;
      logic [3:0]  ctrl;
      logic [31:0] a, b;
      logic [4:0]  rdx;
      logic        rw;
      logic [5:0]  flags;   // {mem_read, mem_write, branch, branch_inv, jump, illegal}
      logic        chk_ab;
      logic        chk_rd;
   } vec_t;

   exp_t m_rec;
   logic m_valid;
   logic m_zero;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference decode written from the instruction-set rules with lookup tables
   function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pcv,
                                       input logic [31:0] a1, input logic [31:0] a2);
      exp_t e;
      logic [2:0] f3;
      logic signed [31:0] hi;
      logic [31:0] imm_i, imm_s, imm_u, sh;
      logic [3:0] op_tab [8];
      logic [3:0] br_tab [8];
      logic [7:0] br_ok, ld_ok, st_ok;
      op_tab = '{4'h0, 4'h5, 4'h8, 4'hB, 4'h2, 4'h6, 4'h3, 4'h4};
      br_tab = '{4'h1, 4'h1, 4'h0, 4'h0, 4'h8, 4'h8, 4'hB, 4'hB};
      br_ok  = 8'b1111_0011;
      ld_ok  = 8'b0011_0111;
      st_ok  = 8'b0000_0111;
      f3     = ins[14:12];
      hi     = $signed(ins) >>> 20;
      imm_i  = hi;
      imm_s  = (hi & ~32'h1F) | ((ins >> 7) & 32'h1F);
      imm_u  = ins & 32'hFFFFF000;
      sh     = (ins >> 20) & 32'h1F;
      e      = '{default: '0};
      e.rd   = ins[11:7];
      e.sd   = a2;
      case (ins[6:0])
         7'h33: begin
            e.ctrl = op_tab[f3];
            if (ins[30] && f3 == 3'd0) e.ctrl = 4'h1;
            if (ins[30] && f3 == 3'd5) e.ctrl = 4'h7;
            e.a = a1; e.b = a2; e.rw = 1'b1;
         end
         7'h13: begin
            e.ctrl = op_tab[f3];
            if (ins[30] && f3 == 3'd5) e.ctrl = 4'h7;
            e.a = a1; e.b = (f3 == 3'd1 || f3 == 3'd5) ? sh : imm_i; e.rw = 1'b1;
         end
         7'h03: if (ld_ok[f3]) begin e.a = a1; e.b = imm_i; e.mr = 1'b1; e.rw = 1'b1; end
                else e.il = 1'b1;
         7'h23: if (st_ok[f3]) begin e.a = a1; e.b = imm_s; e.mw = 1'b1; end
                else e.il = 1'b1;
         7'h63: if (br_ok[f3]) begin
                   e.a = a1; e.b = a2; e.ctrl = br_tab[f3]; e.bi = f3[0]; e.br = 1'b1;
                end else e.il = 1'b1;
         7'h37: begin e.a = 32'd0; e.b = imm_u; e.rw = 1'b1; end
         7'h17: begin e.a = pcv;   e.b = imm_u; e.rw = 1'b1; end
         7'h6F, 7'h67: begin e.a = pcv; e.b = 32'd4; e.jp = 1'b1; e.rw = 1'b1; end
         default: e.il = 1'b1;
      endcase
      if (e.rd == 5'd0) e.rw = 1'b0;
      return e;
   endfunction

   task automatic check_outputs();
      if (m_zero && !m_valid) begin
         chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
         chk("rst_alu_a", alu_a, 32'd0);
         chk("rst_alu_b", alu_b, 32'd0);
         chk("rst_store_data", store_data, 32'd0);
         chk("rst_ctrl_rd", {23'd0, alu_control, rd}, 32'd0);
         chk("rst_flags", {25'd0, reg_write, mem_read, mem_write, branch, branch_inv, jump, illegal}, 32'd0);
      end else begin
         chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
         if (m_valid) begin
            chk("alu_control", {28'd0, alu_control}, {28'd0, m_rec.ctrl});
            chk("flags", {25'd0, reg_write, mem_read, mem_write, branch, branch_inv, jump, illegal},
                {25'd0, m_rec.rw, m_rec.mr, m_rec.mw, m_rec.br, m_rec.bi, m_rec.jp, m_rec.il});
            if (!m_rec.il) begin
               chk("alu_a", alu_a, m_rec.a);
               chk("alu_b", alu_b, m_rec.b);
               chk("rd", {27'd0, rd}, {27'd0, m_rec.rd});
            end
            if (m_rec.mw) chk("store_data", store_data, m_rec.sd);
         end
      end
   endtask

   // One clock: check in_ready, advance the model at the edge, check outputs.
   // Called at a falling edge with inputs already driven; returns at the next one.
   task automatic cycle();
      logic exp_rdy;
      exp_rdy = !rst && !stall && !flush && (!m_valid || out_ready);
      #1;
      chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      @(posedge clk);
      if (rst) begin
         m_valid = 1'b0;
         m_zero  = 1'b1;
      end else if (flush) begin
         m_valid = 1'b0;
      end else if (in_valid && exp_rdy) begin
         m_rec   = ref_decode(instr, pc, rs1_data, rs2_data);
         m_valid = 1'b1;
         m_zero  = 1'b0;
      end else if (out_ready) begin
         m_valid = 1'b0;
      end
      #1;
      check_outputs();
      @(negedge clk);
   endtask

   task automatic drive(input logic [31:0] i, input logic [31:0] p,
                        input logic [31:0] r1, input logic [31:0] r2);
      instr = i; pc = p; rs1_data = r1; rs2_data = r2;
   endtask

   vec_t vecs [13];
   logic [6:0] opc_list [11];

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; stall = 1'b0;
      drive(32'd0, 32'd0, 32'd0, 32'd0);
      m_valid = 1'b0; m_zero = 1'b1; m_rec = '{default: '0};

      vecs[0]  = '{32'h002081B3, 32'h0,   32'd5,        32'd7,        4'h0, 32'd5,        32'd7,        5'd3, 1'b1, 6'b000000, 1'b1, 1'b1};
      vecs[1]  = '{32'h402081B3, 32'h0,   32'd5,        32'd7,        4'h1, 32'd5,        32'd7,        5'd3, 1'b1, 6'b000000, 1'b1, 1'b1};
      vecs[2]  = '{32'hFFF00093, 32'h0,   32'h10,       32'h55,       4'h0, 32'h10,       32'hFFFFFFFF, 5'd1, 1'b1, 6'b000000, 1'b1, 1'b1};
      vecs[3]  = '{32'h40335293, 32'h0,   32'h80000000, 32'h99,       4'h7, 32'h80000000, 32'd3,        5'd5, 1'b1, 6'b000000, 1'b1, 1'b1};
      vecs[4]  = '{32'h0000007F, 32'h0,   32'd1,        32'd2,        4'h0, 32'd0,        32'd0,        5'd0, 1'b0, 6'b000001, 1'b0, 1'b0};
      vecs[5]  = '{32'h123450B7, 32'h40,  32'hAAAA,     32'd0,        4'h0, 32'd0,        32'h12345000, 5'd1, 1'b1, 6'b000000, 1'b1, 1'b1};
      vecs[6]  = '{32'h00001117, 32'h100, 32'd0,        32'd0,        4'h0, 32'h100,      32'h1000,     5'd2, 1'b1, 6'b000000, 1'b1, 1'b1};
      vecs[7]  = '{32'h008000EF, 32'h200, 32'd0,        32'd0,        4'h0, 32'h200,      32'd4,        5'd1, 1'b1, 6'b000010, 1'b1, 1'b1};
      vecs[8]  = '{32'h0020A423, 32'h0,   32'h1000,     32'hDEADBEEF, 4'h0, 32'h1000,     32'd8,        5'd0, 1'b0, 6'b010000, 1'b1, 1'b0};
      vecs[9]  = '{32'h00209063, 32'h0,   32'd3,        32'd4,        4'h1, 32'd3,        32'd4,        5'd0, 1'b0, 6'b001100, 1'b1, 1'b0};
      vecs[10] = '{32'h00500013, 32'h0,   32'd9,        32'd0,        4'h0, 32'd9,        32'd5,        5'd0, 1'b0, 6'b000000, 1'b1, 1'b1};
      vecs[11] = '{32'hFFC0A283, 32'h0,   32'h100,      32'd0,        4'h0, 32'h100,      32'hFFFFFFFC, 5'd5, 1'b1, 6'b100000, 1'b1, 1'b1};
      vecs[12] = '{32'h0000B283, 32'h0,   32'h100,      32'd0,        4'h0, 32'd0,        32'd0,        5'd0, 1'b0, 6'b000001, 1'b0, 1'b0};

      opc_list = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h7F, 7'h0B};

      @(negedge clk);
      // Reset with traffic offered: nothing is taken, everything clears
      in_valid = 1'b1; out_ready = 1'b1;
      drive(32'h002081B3, 32'd0, 32'd5, 32'd7);
      cycle();
      stall = 1'b1;
      cycle();
      rst = 1'b0; stall = 1'b0; in_valid = 1'b0;
      cycle();

      // Directed vectors, full throughput
      for (int k = 0; k < 13; k++) begin
         in_valid = 1'b1; out_ready = 1'b1;
         drive(vecs[k].instr, vecs[k].pc, vecs[k].rs1, vecs[k].rs2);
         cycle();
         chk($sformatf("vec%0d_valid", k), {31'd0, out_valid}, 32'd1);
         chk($sformatf("vec%0d_ctrl", k), {28'd0, alu_control}, {28'd0, vecs[k].ctrl});
         chk($sformatf("vec%0d_rw", k), {31'd0, reg_write}, {31'd0, vecs[k].rw});
         chk($sformatf("vec%0d_flags", k), {26'd0, mem_read, mem_write, branch, branch_inv, jump, illegal},
             {26'd0, vecs[k].flags});
         if (vecs[k].chk_ab) begin
            chk($sformatf("vec%0d_a", k), alu_a, vecs[k].a);
            chk($sformatf("vec%0d_b", k), alu_b, vecs[k].b);
         end
         if (vecs[k].chk_rd) chk($sformatf("vec%0d_rd", k), {27'd0, rd}, {27'd0, vecs[k].rdx});
         if (vecs[k].flags[4]) chk($sformatf("vec%0d_sd", k), store_data, vecs[k].rs2);
      end

      // Backpressure: held entry stays put, nothing accepted, then drains
      drive(32'h002081B3, 32'd0, 32'd5, 32'd7);
      cycle();
      out_ready = 1'b0;
      drive(32'h402081B3, 32'd0, 32'd11, 32'd13);
      for (int k = 0; k < 3; k++) begin
         cycle();
         chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
         chk("bp_hold_ctrl", {28'd0, alu_control}, 32'd0);
         chk("bp_hold_b", alu_b, 32'd7);
      end
      out_ready = 1'b1;
      cycle();
      chk("bp_next_ctrl", {28'd0, alu_control}, 32'd1);
      chk("bp_next_a", alu_a, 32'd11);
      in_valid = 1'b0;
      cycle();
      chk("bp_drained", {31'd0, out_valid}, 32'd0);

      // Flush while holding with a new instruction offered: both disappear
      in_valid = 1'b1;
      drive(32'h002081B3, 32'd0, 32'd1, 32'd2);
      cycle();
      out_ready = 1'b0; flush = 1'b1;
      drive(32'h40335293, 32'd0, 32'd3, 32'd4);
      cycle();
      chk("flush_valid", {31'd0, out_valid}, 32'd0);
      flush = 1'b0; in_valid = 1'b0;
      cycle();
      chk("flush_dropped", {31'd0, out_valid}, 32'd0);

      // Reset in the middle of a stall discards the held entry
      out_ready = 1'b1; in_valid = 1'b1;
      drive(32'hFFF00093, 32'd0, 32'd0, 32'd0);
      cycle();
      out_ready = 1'b0; in_valid = 1'b0; stall = 1'b1;
      cycle();
      rst = 1'b1;
      cycle();
      chk("rst_stall_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_stall_b", alu_b, 32'd0);
      rst = 1'b0; stall = 1'b0;

      // Randomized traffic against the reference model
      for (int k = 0; k < 600; k++) begin
         logic [31:0] r;
         r        = $urandom();
         r[6:0]   = opc_list[$urandom_range(0, 10)];
         in_valid = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         stall    = ($urandom_range(0, 7) == 0);
         flush    = ($urandom_range(0, 15) == 0);
         rst      = ($urandom_range(0, 63) == 0);
         drive(r, $urandom(), $urandom(), $urandom());
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
